// File: rtl/sample_streamer_pkg.sv
// Shared definitions for the sample streamer: FSM state encoding and output FIFO sizing.
// Imported by the RTL and by the testbench.
package sample_streamer_pkg;

  typedef enum logic [1:0] {
    SMPSTR_IDLE  = 2'd0,
    SMPSTR_RUN   = 2'd1,
    SMPSTR_DRAIN = 2'd2
  } smpstr_state_t;

  localparam int SMPSTR_FIFO_DEPTH = 4;
  localparam int SMPSTR_FIFO_CNT_W = $clog2(SMPSTR_FIFO_DEPTH + 1);

endpackage

// File: rtl/smpstr_fifo.sv
// Small synchronous FIFO that buffers ROM samples ahead of the FIR stage.
// Push and pop may happen on the same edge, even when the FIFO is full.
module smpstr_fifo
  import sample_streamer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = SMPSTR_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_fifo_clk,
  input  logic             i_fifo_rst,
  input  logic             i_fifo_push,
  input  logic [WIDTH-1:0] i_fifo_wdata,
  input  logic             i_fifo_pop,
  output logic [WIDTH-1:0] o_fifo_rdata,
  output logic             o_fifo_empty,
  output logic [CNT_W-1:0] o_fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  // A full FIFO may still accept a push when a pop frees the head slot on the same edge.
  assign do_pop  = i_fifo_pop && (count != '0);
  assign do_push = i_fifo_push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge i_fifo_clk) begin
    if (i_fifo_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_fifo_clk) begin
    if (do_push) mem[wr_ptr] <= i_fifo_wdata;
  end

  assign o_fifo_rdata = mem[rd_ptr];
  assign o_fifo_empty = (count == '0);
  assign o_fifo_count = count;

endmodule

// File: rtl/sample_streamer.sv
// Streams NUM_SAMPLES words from a synchronous sample ROM into a FIR stage,
// optionally looping, with credit-based read issue so the output FIFO never overflows.
module sample_streamer
  import sample_streamer_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 101,
  parameter int NUM_SAMPLES = 8,
  parameter int LEN         = $clog2(DEPTH)
) (
  input  logic             i_smpstr_clk,
  input  logic             i_smpstr_rst,
  input  logic             i_smpstr_start,
  input  logic             i_smpstr_loop,
  output logic             o_smpstr_rden,
  output logic [LEN-1:0]   o_smpstr_rdaddr,
  input  logic [WIDTH-1:0] i_smpstr_rddata,
  output logic [WIDTH-1:0] o_smpstr_data,
  output logic             o_smpstr_valid,
  input  logic             i_smpstr_ready,
  output logic             o_smpstr_busy,
  output logic             o_smpstr_done
);

  localparam logic [LEN-1:0] LAST_ADDR = LEN'(NUM_SAMPLES - 1);
  localparam int             OCC_W     = SMPSTR_FIFO_CNT_W + 1;

  smpstr_state_t                state;
  smpstr_state_t                state_next;
  logic [LEN-1:0]               addr;
  logic [LEN-1:0]               addr_next;
  logic                         inflight;
  logic                         inflight_next;
  logic                         rden_raw;
  logic                         done_raw;
  logic [SMPSTR_FIFO_CNT_W-1:0] fifo_count;
  logic                         fifo_empty;
  logic                         fifo_pop;
  logic [OCC_W-1:0]             occupancy;
  logic                         credit_ok;

  // A read is only issued when the FIFO can absorb it alongside any read still in flight.
  assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight);
  assign credit_ok = (occupancy < OCC_W'(SMPSTR_FIFO_DEPTH));

  always_ff @(posedge i_smpstr_clk) begin
    if (i_smpstr_rst) begin
      state    <= SMPSTR_IDLE;
      addr     <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      addr     <= addr_next;
      inflight <= inflight_next;
    end
  end

  always_comb begin
    state_next    = state;
    addr_next     = addr;
    inflight_next = 1'b0;
    rden_raw      = 1'b0;
    done_raw      = 1'b0;
    case (state)
      SMPSTR_IDLE: begin
        if (i_smpstr_start) begin
          state_next = SMPSTR_RUN;
          addr_next  = '0;
        end
      end
      SMPSTR_RUN: begin
        if (credit_ok) begin
          rden_raw      = 1'b1;
          inflight_next = 1'b1;
          // The loop input only matters at the last-address issue.
          if (addr == LAST_ADDR) begin
            addr_next = '0;
            if (!i_smpstr_loop) state_next = SMPSTR_DRAIN;
          end else begin
            addr_next = addr + LEN'(1);
          end
        end
      end
      SMPSTR_DRAIN: begin
        if (!inflight && fifo_empty) begin
          done_raw   = 1'b1;
          state_next = SMPSTR_IDLE;
        end
      end
      default: state_next = SMPSTR_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, not just after it is sampled.
  assign o_smpstr_rden   = rden_raw && !i_smpstr_rst;
  assign o_smpstr_done   = done_raw && !i_smpstr_rst;
  assign o_smpstr_busy   = (state != SMPSTR_IDLE) && !i_smpstr_rst;
  assign o_smpstr_valid  = !fifo_empty && !i_smpstr_rst;
  assign o_smpstr_rdaddr = addr;
  assign fifo_pop        = o_smpstr_valid && i_smpstr_ready;

  smpstr_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (SMPSTR_FIFO_DEPTH),
    .CNT_W (SMPSTR_FIFO_CNT_W)
  ) u_fifo (
    .i_fifo_clk   (i_smpstr_clk),
    .i_fifo_rst   (i_smpstr_rst),
    .i_fifo_push  (inflight),
    .i_fifo_wdata (i_smpstr_rddata),
    .i_fifo_pop   (fifo_pop),
    .o_fifo_rdata (o_smpstr_data),
    .o_fifo_empty (fifo_empty),
    .o_fifo_count (fifo_count)
  );

endmodule

// File: tb/tb_sample_streamer.sv
// Directed testbench for sample_streamer with a synchronous ROM model preloaded 1..8.
// Inputs are driven and outputs sampled 1-2 time units after the rising edge.
module tb_sample_streamer;
  import sample_streamer_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 101;
  localparam int NSAMP = 8;
  localparam int LEN   = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             loop_en;
  logic             rden;
  logic [LEN-1:0]   rdaddr;
  logic [WIDTH-1:0] rddata;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] rom [DEPTH];
  logic             rom_rst_n;

  int               vectors    = 0;
  int               miscompares = 0;
  int               cyc        = 0;
  int               done_cnt   = 0;
  int               done_cyc   = -1;
  int               issue_cnt  = 0;
  logic [WIDTH-1:0] got_data [$];
  int               got_cyc  [$];

  sample_streamer #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .NUM_SAMPLES (NSAMP),
    .LEN         (LEN)
  ) dut (
    .i_smpstr_clk    (clk),
    .i_smpstr_rst    (rst),
    .i_smpstr_start  (start),
    .i_smpstr_loop   (loop_en),
    .o_smpstr_rden   (rden),
    .o_smpstr_rdaddr (rdaddr),
    .i_smpstr_rddata (rddata),
    .o_smpstr_data   (data),
    .o_smpstr_valid  (valid),
    .i_smpstr_ready  (ready),
    .o_smpstr_busy   (busy),
    .o_smpstr_done   (done)
  );

  always #5 clk = ~clk;

  // ROM model: registered read, active-low reset tied to the inverse of the streamer reset.
  assign rom_rst_n = ~rst;
  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = (i < NSAMP) ? WIDTH'(i + 1) : 16'hDEAD;
  end
  always @(posedge clk) begin
    if (!rom_rst_n) rddata <= '0;
    else if (rden)  rddata <= rom[rdaddr];
  end

  task automatic tick();
    #1;
    if (valid && ready) begin
      got_data.push_back(data);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rden) issue_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    got_data.delete();
    got_cyc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    issue_cnt = 0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; loop_en = 1'b0; ready = 1'b1;
    tick();
    tick();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b expected 0", valid); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0)  begin miscompares++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
    vectors++; if (rden !== 1'b0)  begin miscompares++; $display("[TB] FAIL rst_rden: got %b expected 0", rden); end
    rst = 1'b0; start = 1'b0;
    tick();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_valid: got %b expected 0", valid); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("[TB] FAIL post_rst_busy: got %b expected 0", busy); end
    vectors++; if (rden !== 1'b0)  begin miscompares++; $display("[TB] FAIL post_rst_rden: got %b expected 0", rden); end
    vectors++; if (rdaddr !== '0)  begin miscompares++; $display("[TB] FAIL post_rst_addr: got %0d expected 0", rdaddr); end
  endtask

  task automatic test_basic();
    bit to;
    clear_log();
    loop_en = 1'b0; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1)   begin miscompares++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    vectors++; if (rden !== 1'b1)   begin miscompares++; $display("[TB] FAIL basic_rden: got %b expected 1", rden); end
    vectors++; if (rdaddr !== '0)   begin miscompares++; $display("[TB] FAIL basic_addr0: got %0d expected 0", rdaddr); end
    vectors++; if (valid !== 1'b0)  begin miscompares++; $display("[TB] FAIL basic_valid_e1: got %b expected 0", valid); end
    tick();
    vectors++; if (valid !== 1'b0)  begin miscompares++; $display("[TB] FAIL basic_valid_e2: got %b expected 0", valid); end
    tick();
    vectors++; if (valid !== 1'b1)  begin miscompares++; $display("[TB] FAIL basic_valid_e3: got %b expected 1", valid); end
    vectors++; if (data !== 16'd1)  begin miscompares++; $display("[TB] FAIL basic_first_data: got %0d expected 1", data); end
    wait_idle(40, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_timeout: got %b expected 0", to); end
    vectors++; if (got_data.size() !== 8) begin miscompares++; $display("[TB] FAIL basic_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== WIDTH'(i + 1)) begin miscompares++; $display("[TB] FAIL basic_seq[%0d]: got %0d expected %0d", i, got_data[i], i + 1); end
    end
    if (got_cyc.size() == 8) begin
      vectors++; if (got_cyc[7] - got_cyc[0] !== 7) begin miscompares++; $display("[TB] FAIL basic_no_bubble: got span %0d expected 7", got_cyc[7] - got_cyc[0]); end
      vectors++; if (done_cyc !== got_cyc[7] + 1) begin miscompares++; $display("[TB] FAIL basic_done_time: got cycle %0d expected %0d", done_cyc, got_cyc[7] + 1); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_log();
    loop_en = 1'b0; ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    vectors++; if (issue_cnt !== 4) begin miscompares++; $display("[TB] FAIL bp_issues: got %0d expected 4", issue_cnt); end
    vectors++; if (rden !== 1'b0)   begin miscompares++; $display("[TB] FAIL bp_rden: got %b expected 0", rden); end
    vectors++; if (rdaddr !== 7'd4) begin miscompares++; $display("[TB] FAIL bp_addr: got %0d expected 4", rdaddr); end
    vectors++; if (valid !== 1'b1)  begin miscompares++; $display("[TB] FAIL bp_valid: got %b expected 1", valid); end
    vectors++; if (data !== 16'd1)  begin miscompares++; $display("[TB] FAIL bp_head: got %0d expected 1", data); end
    ready = 1'b1;
    wait_idle(40, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_timeout: got %b expected 0", to); end
    vectors++; if (got_data.size() !== 8) begin miscompares++; $display("[TB] FAIL bp_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== WIDTH'(i + 1)) begin miscompares++; $display("[TB] FAIL bp_seq[%0d]: got %0d expected %0d", i, got_data[i], i + 1); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_toggle_ready();
    bit to;
    clear_log();
    loop_en = 1'b0; ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ready = ~ready;
      tick();
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL tog_timeout: got %b expected 0", to); end
    vectors++; if (got_data.size() !== 8) begin miscompares++; $display("[TB] FAIL tog_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== WIDTH'(i + 1)) begin miscompares++; $display("[TB] FAIL tog_seq[%0d]: got %0d expected %0d", i, got_data[i], i + 1); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL tog_done_cnt: got %0d expected 1", done_cnt); end
    ready = 1'b1;
  endtask

  task automatic test_loop();
    bit to;
    clear_log();
    loop_en = 1'b1; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    loop_en = 1'b0;
    wait_idle(60, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL loop_timeout: got %b expected 0", to); end
    // Last-address issues fall 8, 16 and 24 edges after start; the third sees loop low.
    vectors++; if (got_data.size() !== 24) begin miscompares++; $display("[TB] FAIL loop_count: got %0d expected 24", got_data.size()); end
    for (int i = 0; i < 24 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== WIDTH'((i % 8) + 1)) begin miscompares++; $display("[TB] FAIL loop_seq[%0d]: got %0d expected %0d", i, got_data[i], (i % 8) + 1); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL loop_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_midpass();
    bit to;
    clear_log();
    loop_en = 1'b0; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && got_data.size() < 3; i++) tick();
    vectors++; if (got_data.size() !== 3) begin miscompares++; $display("[TB] FAIL mid_pre_count: got %0d expected 3", got_data.size()); end
    rst = 1'b1;
    tick();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid: got %b expected 0", valid); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_post_valid: got %b expected 0", valid); end
    vectors++; if (rden !== 1'b0)  begin miscompares++; $display("[TB] FAIL mid_post_rden: got %b expected 0", rden); end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("[TB] FAIL mid_no_done: got %0d expected 0", done_cnt); end
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(40, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_timeout: got %b expected 0", to); end
    vectors++; if (got_data.size() !== 8) begin miscompares++; $display("[TB] FAIL mid_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== WIDTH'(i + 1)) begin miscompares++; $display("[TB] FAIL mid_seq[%0d]: got %0d expected %0d", i, got_data[i], i + 1); end
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    clear_log();
    loop_en = 1'b0; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_idle(40, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_timeout: got %b expected 0", to); end
    vectors++; if (got_data.size() !== 8) begin miscompares++; $display("[TB] FAIL sb_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== WIDTH'(i + 1)) begin miscompares++; $display("[TB] FAIL sb_seq[%0d]: got %0d expected %0d", i, got_data[i], i + 1); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("[TB] FAIL sb_done_cnt: got %0d expected 1", done_cnt); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_idle: got %b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; ready = 1'b1;
    $display("[TB] sample_streamer directed tests starting");
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle_ready();
    test_loop();
    test_reset_midpass();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 Parameter WIDTH, default 16: sample width in bits.
REQ-002 Parameter DEPTH, default 101: depth of the attached sample ROM.
REQ-003 Parameter NUM_SAMPLES, default 8: number of samples per pass, addresses 0..NUM_SAMPLES-1, NUM_SAMPLES <= DEPTH.
REQ-004 Parameter LEN, default $clog2(DEPTH): ROM address width.
REQ-005 i_smpstr_clk  in  1  single clock; all logic on its rising edge.
REQ-006 i_smpstr_rst  in  1  reset, synchronous and active-high.
REQ-007 i_smpstr_start  in  1  begin a pass; sampled only in IDLE.
REQ-008 i_smpstr_loop  in  1  wrap to address 0 after the last address instead of stopping.
REQ-009 o_smpstr_rden  out  1  ROM read enable.
REQ-010 o_smpstr_rdaddr  out  LEN  ROM read address.
REQ-011 i_smpstr_rddata  in  WIDTH  ROM data, valid one cycle after the edge that sampled rden.
REQ-012 o_smpstr_data  out  WIDTH  sample to the FIR stage.
REQ-013 o_smpstr_valid  out  1  o_smpstr_data holds a sample.
REQ-014 i_smpstr_ready  in  1  FIR stage accepts; transfer when valid and ready are both high at an edge.
REQ-015 o_smpstr_busy  out  1  high in RUN and DRAIN.
REQ-016 o_smpstr_done  out  1  one-cycle pulse at the end of a non-looping pass.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 IDLE -> RUN on start=1; the address counter is loaded with 0.
REQ-019 o_smpstr_rden = (state==RUN) and (fifo_count + inflight < 4), combinational; o_smpstr_rdaddr = address counter.
REQ-020 Each edge with rden=1 is a read issue: inflight flag set for one cycle and the counter advances.
REQ-021 The edge after an issue writes i_smpstr_rddata into a 4-entry output FIFO; inflight is cleared unless a new issue occurs on the same edge.
REQ-022 Issue at address NUM_SAMPLES-1 with loop=1: counter wraps to 0 and state stays RUN; with loop=0: state -> DRAIN.
REQ-023 i_smpstr_loop is evaluated only at the last-address issue; deasserting it mid-pass ends the pass at the end of the current pass.
REQ-024 DRAIN -> IDLE when inflight=0 and the FIFO is empty; o_smpstr_done pulses high for exactly that one transition cycle.
REQ-025 start while busy is ignored; start held high in IDLE after done begins a new pass.
REQ-026 o_smpstr_valid = FIFO not empty; o_smpstr_data = FIFO head; pop on valid and ready.
REQ-027 Simultaneous FIFO push and pop on the same edge: count is unchanged and no data is lost.
REQ-028 Latency: start sampled at edge k -> issue at edge k+1 -> valid high after edge k+2, carrying ROM[0].
REQ-029 With ready held high, valid stays high for NUM_SAMPLES consecutive cycles per pass with no bubbles.
REQ-030 Samples are emitted strictly in address order, with no loss or duplication under any ready pattern.

Reset
REQ-031 rst=1 at an edge forces IDLE, counter=0, inflight=0, FIFO empty; during and after reset: valid=0, busy=0, done=0, rden=0.
REQ-032 Reset mid-pass discards all in-flight and buffered samples; the next start restarts at address 0.
REQ-033 The ROM's active-low reset is driven by the inverse of i_smpstr_rst at integration.

Structure
REQ-034 FSM state encodings and FIFO depth constant (4) are defined in a shared package/include used by the top level and the bench.
REQ-035 The output FIFO is a sub-module, smpstr_fifo (WIDTH, depth 4, count output); all other logic is in sample_streamer.

Verification
REQ-036 ROM preloaded 1..8, NUM_SAMPLES=8, loop=0, ready=1, start pulse -> valid after 2 edges; data 1..8 on 8 consecutive cycles; done pulse one cycle after the last transfer.
REQ-037 Same setup, ready=0 for 10 cycles -> exactly 4 issues then rden=0, FIFO holds 1..4; ready=1 -> 1..8 emitted in order.
REQ-038 Ready toggling every cycle -> sequence 1..8 exact, no duplicates; simultaneous push and pop checked.
REQ-039 loop=1 for 20 cycles, then loop=0 -> output 1..8,1..8,... ends on a sample 8; done pulses once.
REQ-040 rst=1 mid-pass after 3 transfers -> valid=0, busy=0 next cycle; subsequent start yields 1..8 from address 0.
REQ-041 start pulsed while busy -> ignored; exactly 8 samples and one done pulse.
